miner_scheduler: RTL

Work scheduler for the phi1612 mining array. Accepts 640-bit work packets (midstate, data, target) from the host side and loads them into `CORES` miner instances over a shared block bus. Gives each core a distinct nonce lane, sequences the core resets, suppresses pipeline-flush results and tracks nonce-space exhaustion. Arbitrates simultaneous finds into a tagged result FIFO.

---
 rtl/miner_sched_pkg.sv | 23 ++
 rtl/result_fifo.sv | 62 ++++++
 rtl/miner_scheduler.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/miner_sched_pkg.sv
// Shared types and widths for the phi1612 miner work scheduler.
package miner_sched_pkg;

  localparam int unsigned BLOCK_W     = 640;
  localparam int unsigned NONCE_W     = 32;
  localparam int unsigned ID_W        = 8;
  localparam int unsigned LOAD_CYCLES = 3;
  localparam int unsigned RES_W       = ID_W + NONCE_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [NONCE_W-1:0] nonce;
  } result_t;

endpackage

// File: rtl/result_fifo.sv
// Result FIFO: DEPTH storage entries followed by a registered valid/ready output stage.
module result_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             load_out;
  logic             do_push;

  // Output stage refills whenever it is empty or being consumed.
  assign load_out = (count != '0) && (!out_valid || out_ready);
  // A full store still accepts a push when an entry leaves the same cycle.
  assign full_c   = (count == CW'(DEPTH)) && !load_out;
  assign do_push  = push && !full_c;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (load_out) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count + CW'(do_push) - CW'(load_out);
    end
  end

endmodule

// File: rtl/miner_scheduler.sv
// Work scheduler: loads work into the miner array, sequences core resets,
// tracks nonce-space exhaustion and funnels found nonces into a tagged result FIFO.
module miner_scheduler
  import miner_sched_pkg::*;
#(
  parameter int unsigned CORES        = 4,
  parameter int unsigned FLUSH_CYCLES = 64,
  parameter int unsigned RANGE_STEPS  = 32'h4000_0000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     work_valid,
  output logic                     work_ready,
  input  logic [BLOCK_W-1:0]       work_block,
  input  logic [NONCE_W-1:0]       work_nonce_base,
  input  logic [ID_W-1:0]          work_id,
  output logic                     core_reset,
  output logic [BLOCK_W-1:0]       core_block,
  output logic [NONCE_W*CORES-1:0] core_nonce_start,
  input  logic [CORES-1:0]         core_found,
  input  logic [NONCE_W*CORES-1:0] core_nonce,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [NONCE_W-1:0]       res_nonce,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int unsigned PTR_W = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int unsigned CNT_W = 32;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               half_q, half_d;
  logic               core_reset_d, busy_d, done_d;
  logic               accept;

  logic [ID_W-1:0]    id_q;
  logic [CORES-1:0]   pend_valid_q;
  logic [NONCE_W-1:0] pend_nonce_q [CORES];
  logic [PTR_W-1:0]   rr_ptr_q;
  logic               grant_valid;
  logic [PTR_W-1:0]   grant_idx;
  logic               drain;
  logic               fifo_full_c;
  result_t            push_res;
  result_t            out_res;

  // New work always preempts, so the scheduler never back-pressures the host.
  assign work_ready = 1'b1;
  assign accept     = work_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      half_q     <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      half_q     <= half_d;
      core_reset <= core_reset_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next state; outputs are derived from the next state so they align with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    half_d  = half_q;
    if (accept) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      step_d  = '0;
      half_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            step_d  = '0;
            half_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          half_d = !half_q;
          if (half_q) begin
            step_d = step_q + CNT_W'(1);
            if (step_q == CNT_W'(RANGE_STEPS - 1)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end
    core_reset_d = !((state_d == ST_FLUSH) || (state_d == ST_RUN));
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_FLUSH) || (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
  end

  // Work latch and per-core nonce lanes (mod 2^32).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_block       <= '0;
      core_nonce_start <= '0;
      id_q             <= '0;
    end else if (accept) begin
      core_block <= work_block;
      id_q       <= work_id;
      for (int i = 0; i < CORES; i++) begin
        core_nonce_start[i*NONCE_W +: NONCE_W] <= work_nonce_base + NONCE_W'(i);
      end
    end
  end

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < CORES; k++) begin
      if (!grant_valid && pend_valid_q[(int'(rr_ptr_q) + k) % CORES]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'((int'(rr_ptr_q) + k) % CORES);
      end
    end
  end

  assign drain          = grant_valid && !fifo_full_c && !accept;
  assign push_res.id    = id_q;
  assign push_res.nonce = pend_nonce_q[grant_idx];

  // Pending slots: capture order after drain lets a same-cycle capture refill the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= '0;
      rr_ptr_q     <= '0;
      overflow     <= 1'b0;
      for (int i = 0; i < CORES; i++) pend_nonce_q[i] <= '0;
    end else if (accept) begin
      pend_valid_q <= '0;
      rr_ptr_q     <= '0;
      overflow     <= 1'b0;
    end else begin
      if (drain) begin
        pend_valid_q[grant_idx] <= 1'b0;
        rr_ptr_q <= (grant_idx == PTR_W'(CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
      for (int i = 0; i < CORES; i++) begin
        if ((state_q == ST_RUN) && core_found[i]) begin
          if (pend_valid_q[i] && !(drain && (grant_idx == PTR_W'(i)))) begin
            overflow <= 1'b1;
          end else begin
            pend_valid_q[i] <= 1'b1;
            pend_nonce_q[i] <= core_nonce[i*NONCE_W +: NONCE_W];
          end
        end
      end
    end
  end

  result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (accept),
    .push      (drain),
    .push_data (push_res),
    .full_c    (fifo_full_c),
    .out_valid (res_valid),
    .out_data  (out_res),
    .out_ready (res_ready)
  );

  assign res_nonce = out_res.nonce;
  assign res_id    = out_res.id;

endmodule
